// File: rtl/am2910_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : am2910_pipeline_ctrl
// Purpose  : Pipeline-register controller wrapped around an Am2910-style
//            microprogram sequencer. It holds the 32-bit pipeline register
//            (PR), decodes PR into sequencer and datapath controls, and runs
//            an IDLE/SYNC/RUN/HALT state machine that starts, halts and
//            resumes microprogram execution.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start, resume       - one-cycle control pulses
//            y / uaddr           - sequencer address in, control-store address out
//            uword               - control-store data (asynchronous read)
//            cond                - external status flags
//            map_addr, vect_addr - alternate direct-input sources
//            pln, mapn, vectn    - active-low source enables from the sequencer
//            instr, ccn, rldn, ci, plpc, di - sequencer controls
//            dp_ctrl             - datapath control field
//            running, halted, err, ucount - status
// Revision : 1.0 - initial release
// ============================================================================
module am2910_pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        resume,
  input  logic [11:0] y,
  output logic [11:0] uaddr,
  input  logic [31:0] uword,
  input  logic [6:0]  cond,
  input  logic [11:0] map_addr,
  input  logic [11:0] vect_addr,
  input  logic        pln,
  input  logic        mapn,
  input  logic        vectn,
  output logic [3:0]  instr,
  output logic        ccn,
  output logic        rldn,
  output logic        ci,
  output logic        plpc,
  output logic [11:0] di,
  output logic [8:0]  dp_ctrl,
  output logic        running,
  output logic        halted,
  output logic        err,
  output logic [15:0] ucount
);

  // JZ: all fields zero except carry-in, so the sequencer jumps to address 0.
  localparam logic [31:0] C_JZ_WORD   = 32'h0010_0000;
  // CONT with ci=0: the sequencer re-emits the same address every cycle.
  localparam logic [31:0] C_CONT_WORD = 32'h0000_000E;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pr_q, pr_d;
  logic [15:0] ucount_q, ucount_d;
  logic        err_q, err_d;
  logic        fresh_q, fresh_d;   // PR took a new value on the last edge
  logic        count_en;
  logic        src_ok;
  logic [7:0]  cond_ext;
  logic        c_sel;

  // PR field views
  logic [3:0]  pr_instr;
  logic [11:0] pr_branch;
  logic [2:0]  pr_csel;
  logic        pr_cpol;
  logic        pr_ci;
  logic        pr_ld;
  logic        pr_halt;
  logic [8:0]  pr_dp;

  assign pr_instr  = pr_q[3:0];
  assign pr_branch = pr_q[15:4];
  assign pr_csel   = pr_q[18:16];
  assign pr_cpol   = pr_q[19];
  assign pr_ci     = pr_q[20];
  assign pr_ld     = pr_q[21];
  assign pr_halt   = pr_q[22];
  assign pr_dp     = pr_q[31:23];

  // Exactly one source enable asserted (low) is the only legal combination.
  assign src_ok = ({pln, mapn, vectn} == 3'b011) ||
                  ({pln, mapn, vectn} == 3'b101) ||
                  ({pln, mapn, vectn} == 3'b110);

  // csel=7 selects a constant 1 ("always").
  assign cond_ext = {1'b1, cond};
  assign c_sel    = cond_ext[pr_csel];

  always_comb begin
    state_d  = state_q;
    pr_d     = pr_q;
    count_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        pr_d = C_JZ_WORD;
        if (start) state_d = S_SYNC;
      end
      S_SYNC: begin
        // JZ has been in PR for one cycle, so y=0 and uword is word 0.
        pr_d     = uword;
        count_en = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // A halt word gets its one execution cycle before PR is parked.
        if (pr_halt) begin
          pr_d    = C_CONT_WORD;
          state_d = S_HALT;
        end else begin
          pr_d     = uword;
          count_en = 1'b1;
        end
      end
      S_HALT: begin
        pr_d = C_CONT_WORD;
        if (resume) begin
          pr_d     = uword;
          count_en = 1'b1;
          state_d  = S_RUN;
        end
      end
      default: begin
        pr_d    = C_JZ_WORD;
        state_d = S_IDLE;
      end
    endcase

    ucount_d = ucount_q;
    if (count_en && (ucount_q != 16'hFFFF)) ucount_d = ucount_q + 16'd1;

    err_d = err_q | ~src_ok;

    // Reloading an identical word is not a new first cycle.
    fresh_d = (pr_d != pr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pr_q     <= C_JZ_WORD;
      ucount_q <= 16'd0;
      err_q    <= 1'b0;
      fresh_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pr_q     <= pr_d;
      ucount_q <= ucount_d;
      err_q    <= err_d;
      fresh_q  <= fresh_d;
    end
  end

  assign uaddr   = y;
  assign instr   = pr_instr;
  assign ci      = pr_ci;
  assign rldn    = ~pr_ld;
  assign dp_ctrl = pr_dp;
  assign ccn     = ~(c_sel ^ pr_cpol);
  // PL/PC select drops only in the first cycle of RPCT (1001) or TWB (1111).
  assign plpc    = ~(fresh_q && ((pr_instr == 4'b1001) || (pr_instr == 4'b1111)));

  always_comb begin
    di = 12'h000;
    case ({pln, mapn, vectn})
      3'b011:  di = pr_branch;
      3'b101:  di = map_addr;
      3'b110:  di = vect_addr;
      default: di = 12'h000;
    endcase
  end

  assign running = (state_q == S_SYNC) || (state_q == S_RUN);
  assign halted  = (state_q == S_HALT);
  assign err     = err_q;
  assign ucount  = ucount_q;

endmodule
`default_nettype wire

// File: tb/tb_am2910_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_am2910_pipeline_ctrl
// Purpose  : Directed self-checking bench for am2910_pipeline_ctrl. A small
//            control store answers uaddr; expected values are queued as each
//            step is driven and popped when the outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_am2910_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, resume;
  logic [11:0] y, uaddr, map_addr, vect_addr, di;
  logic [31:0] uword;
  logic [6:0]  cond;
  logic        pln, mapn, vectn;
  logic [3:0]  instr;
  logic        ccn, rldn, ci, plpc, running, halted, err;
  logic [8:0]  dp_ctrl;
  logic [15:0] ucount;

  logic [31:0] rom [0:15];
  assign uword = rom[uaddr[3:0]];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  am2910_pipeline_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .resume(resume),
    .y(y), .uaddr(uaddr), .uword(uword), .cond(cond),
    .map_addr(map_addr), .vect_addr(vect_addr),
    .pln(pln), .mapn(mapn), .vectn(vectn),
    .instr(instr), .ccn(ccn), .rldn(rldn), .ci(ci), .plpc(plpc),
    .di(di), .dp_ctrl(dp_ctrl),
    .running(running), .halted(halted), .err(err), .ucount(ucount)
  );

  function automatic logic [31:0] mkword(input logic [3:0] ins, input logic [11:0] br,
                                         input logic [2:0] cs, input logic cp,
                                         input logic c_i, input logic ld,
                                         input logic hlt, input logic [8:0] dp);
    return {dp, hlt, ld, c_i, cp, cs, br, ins};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    expect_v({pfx, "_instr"},   32'h0);   chk(instr);
    expect_v({pfx, "_ccn"},     32'h1);   chk(ccn);
    expect_v({pfx, "_rldn"},    32'h1);   chk(rldn);
    expect_v({pfx, "_ci"},      32'h1);   chk(ci);
    expect_v({pfx, "_plpc"},    32'h1);   chk(plpc);
    expect_v({pfx, "_di"},      32'h0);   chk(di);
    expect_v({pfx, "_dp"},      32'h0);   chk(dp_ctrl);
    expect_v({pfx, "_running"}, 32'h0);   chk(running);
    expect_v({pfx, "_halted"},  32'h0);   chk(halted);
    expect_v({pfx, "_err"},     32'h0);   chk(err);
    expect_v({pfx, "_ucount"},  32'h0);   chk(ucount);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rom[0] = mkword(4'b0011, 12'h00A, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1A5);
    rom[1] = mkword(4'b1001, 12'h123, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h033);
    rom[2] = mkword(4'b0000, 12'h000, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 9'h002);
    rom[3] = mkword(4'b1110, 12'h000, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 9'h055);
    rom[4] = mkword(4'b1010, 12'h0C3, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0F0);

    rst = 1'b1; start = 1'b0; resume = 1'b0; y = 12'h000; cond = 7'h00;
    map_addr = 12'h000; vect_addr = 12'h000; pln = 1'b0; mapn = 1'b1; vectn = 1'b1;

    // Reset state
    tick(); tick();
    chk_reset_outputs("rst");

    // Start sequence: SYNC then RUN with word 0
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    expect_v("sync_running", 32'h1); chk(running);
    expect_v("sync_instr",   32'h0); chk(instr);
    expect_v("sync_ucount",  32'h0); chk(ucount);
    expect_v("sync_uaddr",   32'h0); chk(uaddr);
    tick();
    expect_v("run0_instr",   32'h3);   chk(instr);
    expect_v("run0_dp",      32'h1A5); chk(dp_ctrl);
    expect_v("run0_ucount",  32'h1);   chk(ucount);
    expect_v("run0_running", 32'h1);   chk(running);
    expect_v("run0_rldn",    32'h1);   chk(rldn);

    // Condition select and polarity on csel=2
    cond = 7'b0000100; #1;
    expect_v("cc_pass_ccn", 32'h0);   chk(ccn);
    expect_v("cc_di",       32'h00A); chk(di);
    cond = 7'b0000000; #1;
    expect_v("cc_fail_ccn", 32'h1);   chk(ccn);

    // Repeat instruction: plpc low on first cycle only
    tick();                     // reload word 0, ucount 2
    y = 12'h001;
    tick();
    expect_v("rpct_first_plpc", 32'h0); chk(plpc);
    expect_v("rpct_rldn",       32'h0); chk(rldn);
    expect_v("rpct_ucount",     32'h3); chk(ucount);
    tick();
    expect_v("rpct_again_plpc", 32'h1); chk(plpc);
    y = 12'h002;
    tick();
    expect_v("jz_plpc",   32'h1); chk(plpc);
    expect_v("ucount_5",  32'h5); chk(ucount);

    // Reset mid-run
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrun");

    // start together with rst: reset wins, and machine stays idle
    start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    expect_v("rst_start_running", 32'h0); chk(running);

    // Halt / resume
    y = 12'h000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();                      // PR = word 0, ucount 1
    y = 12'h003;
    tick();                      // PR = halt word, executes
    expect_v("halt_word_dp",      32'h055); chk(dp_ctrl);
    expect_v("halt_word_running", 32'h1);   chk(running);
    expect_v("halt_word_halted",  32'h0);   chk(halted);
    tick();
    for (int i = 0; i < 5; i++) begin
      expect_v("hold_instr",  32'hE); chk(instr);
      expect_v("hold_ci",     32'h0); chk(ci);
      expect_v("hold_halted", 32'h1); chk(halted);
      expect_v("hold_run",    32'h0); chk(running);
      expect_v("hold_ucount", 32'h2); chk(ucount);
      expect_v("hold_dp",     32'h0); chk(dp_ctrl);
      start = (i == 2);          // ignored outside IDLE
      tick();
      start = 1'b0;
    end
    y = 12'h004; resume = 1'b1;
    tick();
    resume = 1'b0;
    expect_v("resume_instr",   32'hA);   chk(instr);
    expect_v("resume_dp",      32'h0F0); chk(dp_ctrl);
    expect_v("resume_running", 32'h1);   chk(running);
    expect_v("resume_halted",  32'h0);   chk(halted);

    // Alternate source and illegal enable combination
    pln = 1'b1; mapn = 1'b0; vectn = 1'b1; map_addr = 12'h5A5; vect_addr = 12'h3C3; #1;
    expect_v("map_di", 32'h5A5); chk(di);
    pln = 1'b1; mapn = 1'b1; vectn = 1'b0; #1;
    expect_v("vect_di", 32'h3C3); chk(di);
    tick();
    expect_v("legal_err", 32'h0); chk(err);
    pln = 1'b1; mapn = 1'b0; vectn = 1'b0; #1;
    expect_v("bad_di", 32'h0); chk(di);
    tick();
    expect_v("bad_err", 32'h1); chk(err);
    pln = 1'b0; mapn = 1'b1; vectn = 1'b1;
    tick();
    expect_v("sticky_err", 32'h1);   chk(err);
    expect_v("pl_di",      32'h0C3); chk(di);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_v("err_cleared", 32'h0); chk(err);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
